// File: rtl/rob_commit_ctrl_pkg.sv
// Shared ROB geometry, entry record layout and the operand-lookup helper.
package rob_commit_ctrl_pkg;
  localparam int ROB_DEPTH  = 16;
  localparam int ROB_TAG_W  = 4;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int CNT_W      = ROB_TAG_W + 1;

  typedef struct packed {
    logic                  busy;
    logic                  ready;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       val;
  } rob_entry_t;

  // {ready, value}; value forced to 0 unless the entry can supply an operand.
  function automatic logic [XLEN:0] qry_lookup(rob_entry_t e, logic byp_hit,
                                               logic [XLEN-1:0] byp_val);
    logic            rdy_o;
    logic [XLEN-1:0] val_o;
    rdy_o = e.busy & (e.ready | byp_hit);
    val_o = '0;
    if (rdy_o) val_o = e.ready ? e.val : byp_val;
    return {rdy_o, val_o};
  endfunction
endpackage

// File: rtl/rob_entry_array.sv
// ROB entry storage: one allocation write port, one CDB update port, a retire
// port and three read ports (head, query 1, query 2).
module rob_entry_array
  import rob_commit_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_all,
  input  logic                  wr_en,
  input  logic [ROB_TAG_W-1:0]  wr_tag,
  input  logic [REG_ADDR_W-1:0] wr_rd,
  input  logic                  cdb_en,
  input  logic [ROB_TAG_W-1:0]  cdb_tag,
  input  logic [XLEN-1:0]       cdb_val,
  input  logic                  ret_en,
  input  logic [ROB_TAG_W-1:0]  ret_tag,
  input  logic [ROB_TAG_W-1:0]  head_tag,
  input  logic [ROB_TAG_W-1:0]  qry_tag1,
  input  logic [ROB_TAG_W-1:0]  qry_tag2,
  output rob_entry_t            head_ent,
  output rob_entry_t            qry_ent1,
  output rob_entry_t            qry_ent2
);
  rob_entry_t ent_q [ROB_DEPTH];
  rob_entry_t ent_d [ROB_DEPTH];

  // Write, CDB and retire never collide on one live entry: the tail is never
  // busy when allocatable and head==tail only when empty or full.
  always_comb begin
    ent_d = ent_q;
    if (clr_all) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        ent_d[i].busy  = 1'b0;
        ent_d[i].ready = 1'b0;
      end
    end else begin
      if (cdb_en && ent_q[cdb_tag].busy) begin
        ent_d[cdb_tag].ready = 1'b1;
        ent_d[cdb_tag].val   = cdb_val;
      end
      if (ret_en) begin
        ent_d[ret_tag].busy  = 1'b0;
        ent_d[ret_tag].ready = 1'b0;
      end
      if (wr_en)
        ent_d[wr_tag] = '{busy: 1'b1, ready: 1'b0, rd: wr_rd, val: ent_q[wr_tag].val};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign head_ent = ent_q[head_tag];
  assign qry_ent1 = ent_q[qry_tag1];
  assign qry_ent2 = ent_q[qry_tag2];
endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer commit controller: head/tail/count control around the entry array.
// Optional ROB_CDB_BYPASS_EN: same-cycle CDB forwarding into head commit and queries.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  alloc_valid,
  input  logic [REG_ADDR_W-1:0] alloc_rd,
  output logic                  alloc_ready,
  output logic [ROB_TAG_W-1:0]  alloc_tag,
  input  logic                  cdb_valid,
  input  logic [ROB_TAG_W-1:0]  cdb_tag,
  input  logic [XLEN-1:0]       cdb_val,
  input  logic                  flush,
  output logic                  rd_in_flag,
  output logic [REG_ADDR_W-1:0] rd_in_a,
  output logic [ROB_TAG_W-1:0]  rd_in_rob,
  output logic                  rd_out_flag,
  output logic [REG_ADDR_W-1:0] rd_out_a,
  output logic [XLEN-1:0]       rd_out_val,
  output logic [ROB_TAG_W-1:0]  rd_out_rob,
  input  logic [ROB_TAG_W-1:0]  qry_tag1,
  input  logic [ROB_TAG_W-1:0]  qry_tag2,
  output logic                  qry_rdy1,
  output logic                  qry_rdy2,
  output logic [XLEN-1:0]       qry_val1,
  output logic [XLEN-1:0]       qry_val2,
  output logic [CNT_W-1:0]      count
);
  logic [ROB_TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  rob_entry_t           head_ent, q1_ent, q2_ent;
  logic                 live, cdb_ok, alloc_fire, commit_fire;
  logic                 head_byp, q1_byp, q2_byp;

  // rst gates the flags so nothing fires while reset is asserted.
  assign live   = rst & rdy & ~flush;
  assign cdb_ok = cdb_valid & live;

`ifdef ROB_CDB_BYPASS_EN
  assign head_byp = cdb_ok & (cdb_tag == head_q);
  assign q1_byp   = cdb_ok & (cdb_tag == qry_tag1);
  assign q2_byp   = cdb_ok & (cdb_tag == qry_tag2);
`else
  assign head_byp = 1'b0;
  assign q1_byp   = 1'b0;
  assign q2_byp   = 1'b0;
`endif

  assign alloc_ready = count_q < CNT_W'(ROB_DEPTH);
  assign alloc_tag   = tail_q;
  assign alloc_fire  = alloc_valid & alloc_ready & live;
  assign commit_fire = live & (count_q != '0) & head_ent.busy & (head_ent.ready | head_byp);

  assign rd_in_flag  = alloc_fire;
  assign rd_in_a     = alloc_rd;
  assign rd_in_rob   = tail_q;
  assign rd_out_flag = commit_fire;
  assign rd_out_a    = head_ent.rd;
  assign rd_out_val  = head_ent.ready ? head_ent.val : cdb_val;
  assign rd_out_rob  = head_q;
  assign count       = count_q;

  assign {qry_rdy1, qry_val1} = qry_lookup(q1_ent, q1_byp, cdb_val);
  assign {qry_rdy2, qry_val2} = qry_lookup(q2_ent, q2_byp, cdb_val);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy && flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_fire)  tail_d = tail_q + 1'b1;
      if (commit_fire) head_d = head_q + 1'b1;
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  rob_entry_array u_array (
    .clk      (clk),
    .rst      (rst),
    .clr_all  (rdy & flush),
    .wr_en    (alloc_fire),
    .wr_tag   (tail_q),
    .wr_rd    (alloc_rd),
    .cdb_en   (cdb_ok),
    .cdb_tag  (cdb_tag),
    .cdb_val  (cdb_val),
    .ret_en   (commit_fire),
    .ret_tag  (head_q),
    .head_tag (head_q),
    .qry_tag1 (qry_tag1),
    .qry_tag2 (qry_tag2),
    .head_ent (head_ent),
    .qry_ent1 (q1_ent),
    .qry_ent2 (q2_ent)
  );
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Scoreboard bench for rob_commit_ctrl: directed scenarios then random traffic
// against an in-order queue model of the ROB.
module tb_rob_commit_ctrl;
  logic        clk, rst, rdy, alloc_valid, cdb_valid, flush;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [3:0]  alloc_tag, cdb_tag, qry_tag1, qry_tag2;
  logic [31:0] cdb_val;
  logic        rd_in_flag, rd_out_flag, qry_rdy1, qry_rdy2;
  logic [4:0]  rd_in_a, rd_out_a;
  logic [3:0]  rd_in_rob, rd_out_rob;
  logic [31:0] rd_out_val, qry_val1, qry_val2;
  logic [4:0]  count;

  rob_commit_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .flush(flush),
    .rd_in_flag(rd_in_flag), .rd_in_a(rd_in_a), .rd_in_rob(rd_in_rob),
    .rd_out_flag(rd_out_flag), .rd_out_a(rd_out_a), .rd_out_val(rd_out_val), .rd_out_rob(rd_out_rob),
    .qry_tag1(qry_tag1), .qry_tag2(qry_tag2), .qry_rdy1(qry_rdy1), .qry_rdy2(qry_rdy2),
    .qry_val1(qry_val1), .qry_val2(qry_val2), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit ar; int tag; int cnt; bit rin; bit rout; bit qchk;
                   bit r1; logic [31:0] v1; bit r2; logic [31:0] v2; } st_t;
  typedef struct { int a; logic [31:0] v; int rob; } wr_t;
  typedef struct { int rd; bit ready; logic [31:0] val; } ment_t;

  st_t   stq[$];
  wr_t   cq[$], rq[$];
  ment_t mq[$];      // in-flight instructions, oldest first
  int    mhead = 0;  // tag of mq[0]
  int    n_tests = 0, n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic qlook(input logic [3:0] t, input bit cok, output bit r, output logic [31:0] v);
    int idx;
    idx = (int'(t) - mhead) & 15;
    r = 0; v = 0;
    if (idx < mq.size()) begin
      if (mq[idx].ready) begin r = 1; v = mq[idx].val; end
`ifdef ROB_CDB_BYPASS_EN
      else if (cok && cdb_tag == t) begin r = 1; v = cdb_val; end
`endif
    end
  endtask

  // Expected behaviour for the inputs just driven, then advance to post-edge state.
  task automatic model();
    st_t e; int n, idx; bit cok, live, com, al; logic [31:0] cval_c;
    if (!rst) begin mq.delete(); mhead = 0; end
    n = mq.size();
    live = rst && rdy && !flush;
    cok  = live && cdb_valid;
    e.ar = n < 16; e.tag = (mhead + n) % 16; e.cnt = n; e.qchk = rdy;
    qlook(qry_tag1, cok, e.r1, e.v1);
    qlook(qry_tag2, cok, e.r2, e.v2);
    com = 0; cval_c = 0;
    if (live && n > 0) begin
      if (mq[0].ready) begin com = 1; cval_c = mq[0].val; end
`ifdef ROB_CDB_BYPASS_EN
      else if (cok && cdb_tag == 4'(mhead)) begin com = 1; cval_c = cdb_val; end
`endif
    end
    al = live && alloc_valid && n < 16;
    e.rin = al; e.rout = com;
    stq.push_back(e);
    if (com) cq.push_back('{mq[0].rd, cval_c, mhead});
    if (al)  rq.push_back('{int'(alloc_rd), 32'h0, e.tag});
    if (cok) begin
      idx = (int'(cdb_tag) - mhead) & 15;
      if (idx < n) begin mq[idx].ready = 1; mq[idx].val = cdb_val; end
    end
    if (com) begin void'(mq.pop_front()); mhead = (mhead + 1) % 16; end
    if (al)  mq.push_back('{int'(alloc_rd), 1'b0, 32'h0});
    if (rst && rdy && flush) begin mq.delete(); mhead = 0; end
  endtask

  task automatic cyc(bit r, bit en, bit av, int ard, bit cv, int ct, logic [31:0] cval, bit fl);
    @(negedge clk);
    rst = r; rdy = en; alloc_valid = av; alloc_rd = 5'(ard);
    cdb_valid = cv; cdb_tag = 4'(ct); cdb_val = cval; flush = fl;
    qry_tag1 = 4'($urandom_range(15)); qry_tag2 = 4'($urandom_range(15));
    model();
  endtask

  // Monitor: compares outputs of each cycle against the queued expectations.
  initial begin
    st_t e; wr_t w;
    forever begin
      @(negedge clk); #2;
      if (stq.size() > 0) begin
        e = stq.pop_front();
        chk("alloc_ready", alloc_ready, e.ar);
        chk("alloc_tag", alloc_tag, e.tag);
        chk("count", count, e.cnt);
        chk("rd_in_flag", rd_in_flag, e.rin);
        chk("rd_out_flag", rd_out_flag, e.rout);
        if (e.qchk) begin
          chk("qry_rdy1", qry_rdy1, e.r1); chk("qry_val1", qry_val1, e.v1);
          chk("qry_rdy2", qry_rdy2, e.r2); chk("qry_val2", qry_val2, e.v2);
        end
        if (rd_in_flag) begin
          chk("rename_pending", rq.size() > 0, 1);
          if (rq.size() > 0) begin
            w = rq.pop_front();
            chk("rd_in_a", rd_in_a, w.a); chk("rd_in_rob", rd_in_rob, w.rob);
          end
        end
        if (rd_out_flag) begin
          chk("commit_pending", cq.size() > 0, 1);
          if (cq.size() > 0) begin
            w = cq.pop_front();
            chk("rd_out_a", rd_out_a, w.a); chk("rd_out_val", rd_out_val, w.v);
            chk("rd_out_rob", rd_out_rob, w.rob);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int ct;
    rst = 0; rdy = 1; alloc_valid = 0; alloc_rd = 0; cdb_valid = 0;
    cdb_tag = 0; cdb_val = 0; flush = 0; qry_tag1 = 0; qry_tag2 = 0;
    // reset with busy inputs: no flags, empty ROB
    repeat (3) cyc(0, 1, 1, 3, 1, 0, 32'h1, 0);
    cyc(1, 1, 1, 5, 0, 0, 0, 0);                 // first alloc rd=5 -> tag 0
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    // out-of-order completion, in-order commit
    cyc(1, 1, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 1, 0, 0, 0, 0); cyc(1, 1, 1, 2, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 1, 32'hAA, 0); cyc(1, 1, 0, 0, 1, 0, 32'h55, 0);
    repeat (3) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    // fill to 16, commit+alloc while full, wrap to tag 0
    cyc(1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 1, 1, i + 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 7, 1, 0, 32'hC0DE, 0);
    cyc(1, 1, 1, 8, 0, 0, 0, 0);
    cyc(1, 1, 1, 9, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    // flush with 3 busy entries and a CDB for head
    cyc(1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, i + 10, 0, 0, 0, 0);
    cyc(1, 1, 1, 4, 1, 0, 32'h77, 1);
    cyc(1, 1, 1, 6, 0, 0, 0, 0);
    // rdy low with a ready head and alloc_valid held
    cyc(1, 1, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 3, 0, 0, 0, 0); cyc(1, 1, 1, 4, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 0, 32'h99, 0);
    repeat (3) cyc(1, 0, 1, 3, 1, 1, 32'h42, 0);
    repeat (3) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    // CDB for head: bypass commits same cycle, otherwise next cycle
    cyc(1, 1, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 0, 32'h1234, 0);
    repeat (2) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, en, fl;
      r  = ($urandom_range(199) != 0);
      en = ($urandom_range(9) != 0);
      fl = en && ($urandom_range(49) == 0);
      if (mq.size() > 0 && $urandom_range(4) != 0)
        ct = (mhead + int'($urandom_range(mq.size() - 1))) % 16;
      else
        ct = int'($urandom_range(15));
      cyc(r, en, $urandom_range(9) < 6, int'($urandom_range(31)),
          $urandom_range(9) < 6, ct, $urandom, fl);
    end
    repeat (40) cyc(1, 1, 0, 0, 1, (mhead) % 16, $urandom, 0);
    @(negedge clk); #4;
    chk("commit_queue_drained", cq.size(), 0);
    chk("rename_queue_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
